// File: rtl/scorer_token_feeder_if.sv
// Event push strobes into the token feeder and the token pulse stream out to the softmax scorer.
// Pushes are fire-and-forget strobes; a token is a one-cycle oFIFO_valid pulse with no ready, and data holds between pulses.
interface scorer_token_feeder_if;
   logic        iSys_valid;
   logic [8:0]  iSys_id;
   logic        iBr_valid;
   logic [11:0] iBr_id;
   logic        oFIFO_valid;
   logic [12:0] oFIFO_data;

   modport master (output iSys_valid, iSys_id, iBr_valid, iBr_id,
                   input  oFIFO_valid, oFIFO_data);
   modport slave  (input  iSys_valid, iSys_id, iBr_valid, iBr_id,
                   output oFIFO_valid, oFIFO_data);
endinterface

// File: rtl/scorer_token_feeder.sv
// Buffers SYS/BR events as scorer tokens and paces their emission to the scorer's busy time,
// giving the scorer's discarded first-after-switch tokens a one-cycle gap.
module scorer_token_feeder #(
   parameter int DEPTH   = 16,
   parameter int SYS_GAP = 14,
   parameter int BR_GAP  = 70
) (
   input  logic                 clk,
   input  logic                 resetn,
   scorer_token_feeder_if.slave bus,
   input  logic                 iFlush,
   output logic                 oFull,
   output logic                 oEmpty,
   output logic [15:0]          oDrop_count,
   output logic                 oDbg_hold
);
   localparam int PW      = $clog2(DEPTH);
   localparam int CW      = PW + 1;
   localparam int GAP_MAX = (SYS_GAP > BR_GAP) ? SYS_GAP : BR_GAP;
   localparam int GW      = $clog2(GAP_MAX + 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
   localparam logic [GW-1:0] SYS_GAP_C = GW'(SYS_GAP);
   localparam logic [GW-1:0] BR_GAP_C  = GW'(BR_GAP);
   localparam logic [GW-1:0] ONE_GAP   = GW'(1);

   typedef enum logic {READY = 1'b0, HOLD = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [12:0]   mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, br_slot;
   logic [CW-1:0] count_q, count_d, free;
   logic [GW-1:0] gap_cnt_q, gap_cnt_d, gap_sel;
   logic          sys_new_q, sys_new_d, br_new_q, br_new_d;
   logic          valid_q, valid_d;
   logic [12:0]   data_q, data_d;
   logic [15:0]   drop_q, drop_d;
   logic [16:0]   drop_sum;
   logic          wr_sys, wr_br, pop;
   logic [1:0]    n_drop;
   logic [12:0]   sys_tok, br_tok, head;

   assign sys_tok = {4'b1000, bus.iSys_id};
   assign br_tok  = {1'b0, bus.iBr_id};
   assign head    = mem_q[rd_ptr_q];
   // Free space ignores a same-cycle pop: the popped slot is reusable only from the next edge.
   assign free    = DEPTH_C - count_q;
   assign br_slot = wr_sys ? wr_ptr_q + PW'(1) : wr_ptr_q;

   always_comb begin : push_arb
      wr_sys = 1'b0;
      wr_br  = 1'b0;
      n_drop = 2'd0;
      if (!iFlush) begin
         if (bus.iSys_valid && bus.iBr_valid) begin
            if (free >= CW'(2)) begin
               wr_sys = 1'b1;
               wr_br  = 1'b1;
            end else if (free == CW'(1)) begin
               wr_sys = 1'b1;
               n_drop = 2'd1;
            end else begin
               n_drop = 2'd2;
            end
         end else if (bus.iSys_valid) begin
            if (free != '0) wr_sys = 1'b1;
            else            n_drop = 2'd1;
         end else if (bus.iBr_valid) begin
            if (free != '0) wr_br = 1'b1;
            else            n_drop = 2'd1;
         end
      end
   end

   always_comb begin : emit_fsm
      state_d   = state_q;
      gap_cnt_d = gap_cnt_q;
      sys_new_d = sys_new_q;
      br_new_d  = br_new_q;
      valid_d   = 1'b0;
      data_d    = data_q;
      pop       = 1'b0;
      gap_sel   = ONE_GAP;
      case (state_q)
         READY: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               valid_d = 1'b1;
               data_d  = head;
               if (head[12]) begin
                  gap_sel   = sys_new_q ? ONE_GAP : SYS_GAP_C;
                  sys_new_d = 1'b0;
                  br_new_d  = 1'b1;
               end else begin
                  gap_sel   = br_new_q ? ONE_GAP : BR_GAP_C;
                  br_new_d  = 1'b0;
               end
               gap_cnt_d = gap_sel;
               // A one-cycle gap never enters HOLD, so the next token goes out back-to-back.
               if (gap_sel > ONE_GAP) state_d = HOLD;
            end
         end
         HOLD: begin
            gap_cnt_d = gap_cnt_q - ONE_GAP;
            if (gap_cnt_d <= ONE_GAP) state_d = READY;
         end
         default: state_d = READY;
      endcase
      if (iFlush) begin
         state_d   = READY;
         gap_cnt_d = '0;
         sys_new_d = 1'b1;
         br_new_d  = 1'b1;
         valid_d   = 1'b0;
         data_d    = data_q;
         pop       = 1'b0;
      end
   end

   always_comb begin : ptr_next
      wr_ptr_d = wr_ptr_q + PW'(wr_sys) + PW'(wr_br);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(wr_sys) + CW'(wr_br) - CW'(pop);
      drop_sum = {1'b0, drop_q} + 17'(n_drop);
      drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (iFlush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk) begin : store
      if (wr_sys) mem_q[wr_ptr_q] <= sys_tok;
      if (wr_br)  mem_q[br_slot]  <= br_tok;
   end

   always_ff @(posedge clk or negedge resetn) begin : regs
      if (!resetn) begin
         state_q   <= READY;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         gap_cnt_q <= '0;
         sys_new_q <= 1'b1;
         br_new_q  <= 1'b1;
         valid_q   <= 1'b0;
         data_q    <= '0;
         drop_q    <= '0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         gap_cnt_q <= gap_cnt_d;
         sys_new_q <= sys_new_d;
         br_new_q  <= br_new_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         drop_q    <= drop_d;
      end
   end

   assign bus.oFIFO_valid = valid_q;
   assign bus.oFIFO_data  = data_q;
   assign oFull           = (count_q == DEPTH_C);
   assign oEmpty          = (count_q == '0);
   assign oDrop_count     = drop_q;
   assign oDbg_hold       = (state_q == HOLD);
endmodule

// File: tb/tb_scorer_token_feeder.sv
// Bench for scorer_token_feeder: directed vector table, timed corner sequences and random traffic
// against a time-based queue model of the feeder.
module tb_scorer_token_feeder;
   localparam int DEPTH   = 16;
   localparam int SYS_GAP = 14;
   localparam int BR_GAP  = 70;

   logic        clk = 1'b0;
   logic        resetn;
   logic        iFlush;
   logic        oFull, oEmpty, oDbg_hold;
   logic [15:0] oDrop_count;

   scorer_token_feeder_if bus();

   scorer_token_feeder #(.DEPTH(DEPTH), .SYS_GAP(SYS_GAP), .BR_GAP(BR_GAP)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .bus         (bus),
      .iFlush      (iFlush),
      .oFull       (oFull),
      .oEmpty      (oEmpty),
      .oDrop_count (oDrop_count),
      .oDbg_hold   (oDbg_hold)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [12:0] exp_q[$];
   int          cyc      = 0;
   int          next_ok  = 0;
   bit          m_sys_new = 1'b1;
   bit          m_br_new  = 1'b1;
   int          m_drop    = 0;
   logic        m_valid   = 1'b0;
   logic [12:0] m_data    = '0;
   int          pulse_t[$];

   typedef struct {
      bit          sv;
      logic [8:0]  sid;
      bit          bv;
      logic [11:0] bid;
      bit          fl;
      bit          ev;
      logic [12:0] ed;
   } vec_t;
   vec_t tbl[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
   endtask

   task automatic model_reset();
      exp_q.delete();
      next_ok   = 0;
      m_sys_new = 1'b1;
      m_br_new  = 1'b1;
      m_drop    = 0;
      m_valid   = 1'b0;
      m_data    = '0;
   endtask

   // Time-based model: a token may leave once the clock reaches the slot granted by the previous one.
   task automatic model_edge(input bit sv, input logic [8:0] sid, input bit bv,
                             input logic [11:0] bid, input bit fl);
      int          sz, room, gap;
      logic [12:0] hd;
      if (fl) begin
         exp_q.delete();
         next_ok   = 0;
         m_sys_new = 1'b1;
         m_br_new  = 1'b1;
         m_valid   = 1'b0;
      end else begin
         sz      = exp_q.size();
         room    = DEPTH - sz;
         m_valid = 1'b0;
         if (sz > 0 && cyc >= next_ok) begin
            hd      = exp_q.pop_front();
            m_valid = 1'b1;
            m_data  = hd;
            if (hd[12]) begin
               gap       = m_sys_new ? 1 : SYS_GAP;
               m_sys_new = 1'b0;
               m_br_new  = 1'b1;
            end else begin
               gap      = m_br_new ? 1 : BR_GAP;
               m_br_new = 1'b0;
            end
            next_ok = cyc + gap;
         end
         if (sv) begin
            if (room > 0) begin exp_q.push_back({4'b1000, sid}); room--; end
            else m_drop++;
         end
         if (bv) begin
            if (room > 0) begin exp_q.push_back({1'b0, bid}); room--; end
            else m_drop++;
         end
         if (m_drop > 65535) m_drop = 65535;
      end
      cyc++;
   endtask

   task automatic step(input bit sv, input logic [8:0] sid, input bit bv,
                       input logic [11:0] bid, input bit fl);
      @(negedge clk);
      bus.iSys_valid = sv;
      bus.iSys_id    = sid;
      bus.iBr_valid  = bv;
      bus.iBr_id     = bid;
      iFlush         = fl;
      @(posedge clk);
      model_edge(sv, sid, bv, bid, fl);
      #1;
      check("valid", bus.oFIFO_valid, m_valid);
      check("data",  bus.oFIFO_data,  m_data);
      check("full",  oFull,  exp_q.size() == DEPTH);
      check("empty", oEmpty, exp_q.size() == 0);
      check("drop",  oDrop_count, m_drop);
      check("hold",  oDbg_hold, cyc < next_ok);
      if (bus.oFIFO_valid) pulse_t.push_back(cyc);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 9'h0, 1'b0, 12'h0, 1'b0);
   endtask

   task automatic check_gap(input string name, input int idx, input int exp_gap);
      if (pulse_t.size() > idx) check(name, pulse_t[idx] - pulse_t[idx-1], exp_gap);
      else check({name, "_missing"}, pulse_t.size(), idx + 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int guard;
      int drop_before;

      resetn         = 1'b0;
      iFlush         = 1'b0;
      bus.iSys_valid = 1'b0;
      bus.iSys_id    = '0;
      bus.iBr_valid  = 1'b0;
      bus.iBr_id     = '0;
      #12;
      check("rst_valid", bus.oFIFO_valid, 1'b0);
      check("rst_data",  bus.oFIFO_data,  13'h0);
      check("rst_full",  oFull,  1'b0);
      check("rst_empty", oEmpty, 1'b1);
      check("rst_drop",  oDrop_count, 16'h0);
      @(negedge clk);
      resetn = 1'b1;
      model_reset();

      // First SYS is a discard (gap 1); the second SYS then opens a 14-cycle window.
      tbl[0] = '{1'b1, 9'h05A, 1'b0, 12'h0, 1'b0, 1'b0, 13'h0000};
      tbl[1] = '{1'b1, 9'h003, 1'b0, 12'h0, 1'b0, 1'b1, 13'h105A};
      tbl[2] = '{1'b0, 9'h000, 1'b0, 12'h0, 1'b0, 1'b1, 13'h1003};
      tbl[3] = '{1'b0, 9'h000, 1'b0, 12'h0, 1'b0, 1'b0, 13'h1003};
      tbl[4] = '{1'b0, 9'h000, 1'b0, 12'h0, 1'b0, 1'b0, 13'h1003};
      pulse_t.delete();
      for (int i = 0; i < 5; i++) begin
         step(tbl[i].sv, tbl[i].sid, tbl[i].bv, tbl[i].bid, tbl[i].fl);
         check("tbl_valid", bus.oFIFO_valid, tbl[i].ev);
         check("tbl_data",  bus.oFIFO_data,  tbl[i].ed);
      end
      step(1'b1, 9'h001, 1'b0, 12'h0, 1'b0);
      step(1'b1, 9'h002, 1'b0, 12'h0, 1'b0);
      idle(40);
      check("sys_pulses", pulse_t.size(), 4);
      check_gap("sys_gap_discard", 1, 1);
      check_gap("sys_gap_a", 2, SYS_GAP);
      check_gap("sys_gap_b", 3, SYS_GAP);

      // SYS, BR, BR: both type-switch tokens go out back-to-back, then BR holds 70.
      step(1'b0, 9'h0, 1'b0, 12'h0, 1'b1);
      pulse_t.delete();
      step(1'b1, 9'h010, 1'b0, 12'h000, 1'b0);
      step(1'b0, 9'h000, 1'b1, 12'hABC, 1'b0);
      step(1'b0, 9'h000, 1'b1, 12'h123, 1'b0);
      check("br_abc_data", bus.oFIFO_data, 13'h0ABC);
      step(1'b0, 9'h000, 1'b1, 12'h456, 1'b0);
      check("br_123_data", bus.oFIFO_data, 13'h0123);
      idle(80);
      check("mix_pulses", pulse_t.size(), 4);
      check_gap("mix_gap_sys", 1, 1);
      check_gap("mix_gap_brnew", 2, 1);
      check_gap("mix_gap_br", 3, BR_GAP);

      // Dual push with one free slot and no pop on that edge.
      step(1'b0, 9'h0, 1'b0, 12'h0, 1'b1);
      guard = 0;
      while (!(exp_q.size() == DEPTH-1 && cyc < next_ok) && guard < 500) begin
         if (exp_q.size() < DEPTH-1) step(1'b1, 9'($urandom_range(0, 511)), 1'b0, 12'h0, 1'b0);
         else idle(1);
         guard++;
      end
      check("fill15_bound", guard < 500, 1'b1);
      drop_before = m_drop;
      step(1'b1, 9'h1EE, 1'b1, 12'hBAD, 1'b0);
      check("dual_drop", oDrop_count, drop_before + 1);
      check("dual_full", oFull, 1'b1);
      guard = 0;
      while (exp_q.size() > 0 && guard < 2000) begin
         idle(1);
         guard++;
      end
      check("drain_bound", guard < 2000, 1'b1);
      check("drain_last", bus.oFIFO_data, 13'h11EE);
      check("drain_empty", oEmpty, 1'b1);

      // Flush while full and holding, with a simultaneous push.
      guard = 0;
      while (!(exp_q.size() == DEPTH && cyc < next_ok) && guard < 500) begin
         if (exp_q.size() < DEPTH) step(1'b1, 9'($urandom_range(0, 511)), 1'b0, 12'h0, 1'b0);
         else idle(1);
         guard++;
      end
      check("fill16_bound", guard < 500, 1'b1);
      check("fill16_full", oFull, 1'b1);
      drop_before = m_drop;
      step(1'b1, 9'h0F0, 1'b1, 12'h0F0, 1'b1);
      check("flush_empty", oEmpty, 1'b1);
      check("flush_drop", oDrop_count, drop_before);
      pulse_t.delete();
      step(1'b1, 9'h0AA, 1'b0, 12'h0, 1'b0);
      step(1'b1, 9'h0BB, 1'b0, 12'h0, 1'b0);
      idle(3);
      check("flush_pulses", pulse_t.size(), 2);
      check_gap("flush_gap", 1, 1);

      // Asynchronous reset in the middle of a hold with five tokens queued.
      step(1'b0, 9'h0, 1'b0, 12'h0, 1'b1);
      for (int i = 0; i < 7; i++) step(1'b1, 9'(9'h020 + i), 1'b0, 12'h0, 1'b0);
      check("pre_rst_hold", oDbg_hold, 1'b1);
      #2;
      resetn         = 1'b0;
      bus.iSys_valid = 1'b0;
      bus.iBr_valid  = 1'b0;
      #1;
      check("arst_valid", bus.oFIFO_valid, 1'b0);
      check("arst_data",  bus.oFIFO_data,  13'h0);
      check("arst_full",  oFull,  1'b0);
      check("arst_empty", oEmpty, 1'b1);
      check("arst_drop",  oDrop_count, 16'h0);
      check("arst_hold",  oDbg_hold, 1'b0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      pulse_t.delete();
      idle(30);
      check("post_rst_pulses", pulse_t.size(), 0);
      step(1'b1, 9'h077, 1'b0, 12'h0, 1'b0);
      idle(2);
      check("post_rst_resume", pulse_t.size(), 1);

      // Random traffic with occasional flushes.
      for (int i = 0; i < 700; i++) begin
         step($urandom_range(0, 99) < 45, 9'($urandom_range(0, 511)),
              $urandom_range(0, 99) < 35, 12'($urandom_range(0, 4095)),
              $urandom_range(0, 249) == 0);
      end
      idle(5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/scorer_token_feeder.md
# scorer_token_feeder

Producer end of the 13-bit token FIFO interface that feeds the softmax anomaly scorer. Buffers syscall (SYS) and branch (BR) events, encodes them as scorer tokens and emits them as single-cycle valid pulses. The scorer has no ready signal, so emissions are paced to its busy time. The block mirrors the scorer's "first token after a type switch is discarded" rule so that discarded tokens cost only one cycle.

## Interface
- DEPTH, 16: token buffer entries, power of two, at least 4.
- SYS_GAP, 14: minimum cycles between a processed SYS emission and the next emission.
- BR_GAP, 70: minimum cycles between a processed BR emission and the next emission.
- clk  in  1  clock; all logic is on the rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- iSys_valid  in  1  SYS event push strobe.
- iSys_id  in  9  syscall index.
- iBr_valid  in  1  BR event push strobe.
- iBr_id  in  12  branch index.
- iFlush  in  1  synchronous flush.
- oFIFO_valid  out  1  token strobe to the scorer; one-cycle pulse, registered.
- oFIFO_data  out  13  token. SYS token = {1'b1, 3'b000, id[8:0]}. BR token = {1'b0, id[11:0]}.
- oFull  out  1  count == DEPTH.
- oEmpty  out  1  count == 0.
- oDrop_count  out  16  number of events dropped because the buffer was full; saturates at 16'hFFFF.

## Operation
- Buffer is a circular FIFO with wr_ptr, rd_ptr and count (0..DEPTH). Pointers wrap modulo DEPTH.
- Pushes:
  - iSys_valid alone writes one entry if count < DEPTH; otherwise the event is dropped.
  - iBr_valid alone follows the same rule.
  - When both are high in the same cycle, SYS is written at wr_ptr and BR at wr_ptr+1. With exactly one free slot, SYS is kept and BR is dropped. With no free slot, both are dropped.
  - A same-cycle pop frees its slot only from the next cycle onward.
- Each dropped event adds 1 to oDrop_count, so a dual drop adds 2. The counter saturates.
- State machine has two states, READY and HOLD.
  - READY with count > 0: pop the head, drive oFIFO_valid=1 and oFIFO_data=head on the next edge, load gap_cnt, go to HOLD.
  - READY with count == 0: stay in READY.
  - HOLD: decrement gap_cnt. Return to READY on the edge where gap_cnt reaches 1.
- New-flags sys_new and br_new both reset to 1.
- Emitting a SYS token:
  - gap = 1 if sys_new, else SYS_GAP.
  - Then sys_new <= 0 and br_new <= 1.
- Emitting a BR token:
  - gap = 1 if br_new, else BR_GAP.
  - Then br_new <= 0.
- With gap = 1, the block skips HOLD and stays in READY, so emissions are back-to-back.
- iFlush:
  - Sets count, wr_ptr and rd_ptr to 0, state to READY and gap_cnt to 0.
  - Sets both new-flags to 1 and oFIFO_valid to 0.
  - Pushes in the same cycle are ignored and not counted as drops.
  - oDrop_count is kept.
- Reset values:
  - oFIFO_valid = 0, oFIFO_data = 0, oFull = 0, oEmpty = 1, oDrop_count = 0.
  - State READY, both new-flags 1, pointers and count 0.
- Reset asserted mid-HOLD aborts the hold. Tokens lost this way are not counted as drops.

## Timing
- Push to emit: an event pushed on edge k into an empty buffer while in READY drives oFIFO_valid high during the cycle after edge k+1 (2-cycle latency). There is no bypass path.
- Emission spacing: if an emission is valid during cycle E, the next one is valid no earlier than cycle E+gap.
- This matches the scorer's acceptance windows: it takes a token in IDLE, runs counter values 0..12 (SYS) or 0..68 (BR), and is back in IDLE 14 or 70 cycles after the accept.
- oFIFO_data holds its value between pulses. Only oFIFO_valid is the qualifier.
- oFull and oEmpty reflect count after the current edge's push and pop.

## Test plan
- Single SYS event id 0x05A after reset → oFIFO_valid pulse 2 cycles later with data 13'h105A. sys_new was 1, so a SYS event id 0x003 pushed next is emitted on the very next cycle as 13'h1003.
- Two more SYS events (ids 1 and 2) after the first two → their emissions are exactly 14 cycles apart. No emission occurs inside the window.
- Alternate SYS, BR, BR pushes (BR ids 0xABC, 0x123) → SYS pulse, then BR 0xABC one cycle later (br_new discard), then BR 0x123 one cycle after that. A following BR is held exactly 70 cycles.
- Simultaneous SYS and BR pushes with count = DEPTH−1 → SYS stored, BR dropped, oDrop_count increments by 1, oFull = 1. Draining then shows the head tokens in order and correct pointer wrap.
- Fill to DEPTH, then pulse iFlush during HOLD together with a push → oEmpty = 1 next cycle, push ignored, oDrop_count unchanged. The next SYS is emitted as a discard-gap token (1-cycle gap).
- Assert resetn low mid-HOLD with 5 entries queued → all outputs take their reset values asynchronously. After release, no oFIFO_valid pulse appears until a new push.
